image_read_sched: RTL and testbench
===================================

// Module: image_read_sched
// PURPOSE
//  Pass scheduler for image_read. Replays the image segment held in image_mem once per kernel bank.
//  Per pass: wait for a loaded kernel bank, pulse image_read's next, watch its output stream until the last beat is accepted, release the bank.
//  Sits between the cfg bus / layer controller and image_read + kernel loader; repeats for the configured pass count, then reports done.
// PARAMETERS
//  CFG_DWIDTH     32   cfg bus data width
//  CFG_AWIDTH     5    cfg bus address width
//  CFG_PASS_ADDR  20   cfg address of pass-count register (data[PASS_WIDTH-1:0])
//  PASS_WIDTH     16   pass counter width; cfg value 0 = 1 pass
//  GAP_CYCLES     4    idle cycles between last-beat accept and next next pulse (>=1)
//  TMO_WIDTH      24   watchdog width; a pass exceeding 2**TMO_WIDTH-1 cycles is a timeout
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous, active-high reset
//  cfg_data   in   CFG_DWIDTH  cfg write data
//  cfg_addr   in   CFG_AWIDTH  cfg write address
//  cfg_valid  in   1           cfg write strobe
//  start      in   1           pulse: begin a run (ignored unless IDLE)
//  abort      in   1           pulse: stop the run after the current pass
//  ker_ready  in   1           kernel bank loaded and valid
//  ker_next   out  1           pulse: current kernel bank consumed
//  ir_next    out  1           pulse to image_read next
//  ir_val     in   1           image_read image_val (monitored)
//  ir_rdy     in   1           downstream image_rdy (monitored)
//  ir_last    in   1           image_read image_last (monitored)
//  busy       out  1           run in progress
//  done       out  1           pulse: run finished (normal, abort or timeout)
//  err        out  1           sticky timeout flag; cleared by start or rst
//  pass_cnt   out  PASS_WIDTH  completed passes in current/last run
// BEHAVIOUR
//  Reset: state IDLE; ker_next=ir_next=done=busy=err=0; pass_cnt=0; cfg_passes=0.
//  cfg_passes loads on cfg_valid & cfg_addr==CFG_PASS_ADDR. It is sampled into a run copy at start;
//  cfg writes mid-run affect only the next run.
//  States: IDLE, WAIT_KER, ISSUE, RUN, GAP, DONE (one-hot; an illegal encoding goes to IDLE).
//  IDLE:     start -> WAIT_KER. On entry: pass_cnt=0, err=0, target=cfg_passes+1, busy=1.
//  WAIT_KER: ker_ready=1 -> ISSUE. abort -> DONE.
//  ISSUE:    exactly one cycle. ir_next=1 (registered, so it is asserted the cycle after entry); -> RUN.
//            The watchdog clears.
//  RUN:      watchdog +1/cycle. Last beat = ir_val&ir_rdy&ir_last.
//            On last beat: ker_next=1 pulse, pass_cnt+1, -> GAP.
//            Watchdog saturating at all-ones -> err=1, ker_next=1, -> DONE.
//            ir_last without ir_val&ir_rdy is ignored. abort in RUN is latched and acted on at the last beat.
//  GAP:      counts GAP_CYCLES (lets image_read pass RESET->CONFIG).
//            Then, if pass_cnt==target or abort latched -> DONE, else -> WAIT_KER.
//  DONE:     one cycle. done=1, busy=0, abort latch cleared; -> IDLE. pass_cnt holds until the next start.
//  Minimum spacing between consecutive ir_next pulses = RUN time + GAP_CYCLES + 2.
//  start while busy: ignored. start and abort in the same cycle in IDLE: start wins, and abort is dropped.
//  pass_cnt wraps modulo 2**PASS_WIDTH; at most 2**PASS_WIDTH passes can be configured.
//  rst mid-run: immediate return to IDLE, all outputs at reset values; no ker_next or done is emitted.
//  Monitor inputs never stall image_read; this block is an observer on the image stream.
// TESTING
//  cfg_passes=2, ker_ready=1, start, 10-beat stream per pass -> 3 ir_next, 3 ker_next, pass_cnt=3, 1 done.
//  ker_ready=0 for 50 cycles after start -> no ir_next until ker_ready rises; ir_next 2 cycles after the rise.
//  ir_last with ir_rdy=0 for 5 cycles, then rdy=1 -> pass counted only on the accepted cycle.
//  TMO_WIDTH=6, stream never ends -> err=1 and done at cycle 63 of RUN; ker_next pulses once.
//  cfg_passes=4, abort during pass 2 -> pass 2 completes, done, pass_cnt=2, no 3rd ir_next.
//  rst asserted in RUN -> next cycle: busy=0, pass_cnt=0; a new start runs a full sequence.

Source files
------------

// File: rtl/image_read_sched_if.sv
// Control/monitor bundle between the pass scheduler, the cfg bus, the layer
// controller, the kernel loader and image_read.
interface image_read_sched_if #(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned CFG_AWIDTH = 5,
    parameter int unsigned PASS_WIDTH = 16
);
    logic [CFG_DWIDTH-1:0] cfg_data;
    logic [CFG_AWIDTH-1:0] cfg_addr;
    logic                  cfg_valid;
    logic                  start;
    logic                  abort;
    logic                  ker_ready;
    logic                  ker_next;
    logic                  ir_next;
    logic                  ir_val;
    logic                  ir_rdy;
    logic                  ir_last;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [PASS_WIDTH-1:0] pass_cnt;

    modport master (
        output cfg_data, cfg_addr, cfg_valid, start, abort, ker_ready,
               ir_val, ir_rdy, ir_last,
        input  ker_next, ir_next, busy, done, err, pass_cnt
    );

    modport slave (
        input  cfg_data, cfg_addr, cfg_valid, start, abort, ker_ready,
               ir_val, ir_rdy, ir_last,
        output ker_next, ir_next, busy, done, err, pass_cnt
    );
endinterface

// File: rtl/image_read_sched.sv
// Pass scheduler for image_read: replays the image segment once per loaded
// kernel bank, watching the output stream for the accepted last beat.
module image_read_sched #(
    parameter int unsigned CFG_DWIDTH    = 32,
    parameter int unsigned CFG_AWIDTH    = 5,
    parameter int unsigned CFG_PASS_ADDR = 20,
    parameter int unsigned PASS_WIDTH    = 16,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned TMO_WIDTH     = 24
) (
    input logic               clk,
    input logic               rst,
    image_read_sched_if.slave bus
);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
    localparam logic [PASS_WIDTH:0]   RUN_ONE  = (PASS_WIDTH + 1)'(1);
    localparam logic [TMO_WIDTH-1:0]  TMO_ONE  = TMO_WIDTH'(1);
    localparam logic [CFG_AWIDTH-1:0] PASS_ADR = CFG_AWIDTH'(CFG_PASS_ADDR);

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_WAIT_KER = 6'b000010,
        S_ISSUE    = 6'b000100,
        S_RUN      = 6'b001000,
        S_GAP      = 6'b010000,
        S_DONE     = 6'b100000
    } state_e;

    state_e                state_q, state_d;
    logic [PASS_WIDTH-1:0] cfg_passes_q;
    // One bit wider than pass_cnt so a full 2**PASS_WIDTH-pass run terminates.
    logic [PASS_WIDTH:0]   target_q, target_d;
    logic [PASS_WIDTH:0]   runs_q, runs_d;
    logic [TMO_WIDTH-1:0]  wdog_q, wdog_d, wdog_inc;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  abort_q, abort_d;
    logic                  err_q, err_d;
    logic                  ker_next_q, ker_next_d;
    logic                  ir_next_q, ir_next_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_beat, tmo;
    logic                  unused_cfg_data;

    assign unused_cfg_data = ^bus.cfg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_passes_q <= '0;
        end else if (bus.cfg_valid && bus.cfg_addr == PASS_ADR) begin
            cfg_passes_q <= bus.cfg_data[PASS_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        runs_d     = runs_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        abort_d    = abort_q;
        err_d      = err_q;
        ker_next_d = 1'b0;
        last_beat  = bus.ir_val & bus.ir_rdy & bus.ir_last;
        wdog_inc   = wdog_q + TMO_ONE;
        tmo        = &wdog_inc;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_WAIT_KER;
                    runs_d   = '0;
                    err_d    = 1'b0;
                    abort_d  = 1'b0;
                    target_d = {1'b0, cfg_passes_q} + RUN_ONE;
                end
            end
            S_WAIT_KER: begin
                if (bus.abort || abort_q) begin
                    state_d = S_DONE;
                end else if (bus.ker_ready) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wdog_d = wdog_inc;
                if (last_beat) begin
                    ker_next_d = 1'b1;
                    runs_d     = runs_q + RUN_ONE;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end else if (tmo) begin
                    ker_next_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (runs_q == target_q || abort_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_KER;
                    end
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Aborts mid-run are held until the current pass has drained.
        if (bus.abort && state_q != S_IDLE && state_q != S_DONE) begin
            abort_d = 1'b1;
        end

        ir_next_d = (state_q == S_ISSUE);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            runs_q     <= '0;
            wdog_q     <= '0;
            gap_q      <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            ker_next_q <= 1'b0;
            ir_next_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            runs_q     <= runs_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
            ker_next_q <= ker_next_d;
            ir_next_q  <= ir_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ker_next = ker_next_q;
    assign bus.ir_next  = ir_next_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pass_cnt = runs_q[PASS_WIDTH-1:0];
endmodule

// File: tb/tb_image_read_sched.sv
// Directed bench for image_read_sched: multi-pass runs, kernel stalls,
// back-pressured last beat, watchdog timeout, abort and mid-run reset.
module tb_image_read_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   irn = 0, kn = 0, dn = 0;
    int   b_irn, b_kn, b_dn, cyc;

    image_read_sched_if #(.CFG_DWIDTH(32), .CFG_AWIDTH(5), .PASS_WIDTH(16)) bus ();

    image_read_sched #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .CFG_PASS_ADDR(20),
        .PASS_WIDTH(16), .GAP_CYCLES(4), .TMO_WIDTH(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ir_next)  irn++;
        if (bus.ker_next) kn++;
        if (bus.done)     dn++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_addr  = 5'(addr);
        bus.cfg_data  = 32'(data);
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_for(input string tag, input bit want_done, input int limit,
                            output int cycles);
        cycles = 0;
        while (!(want_done ? bus.done : bus.ir_next) && cycles < limit) begin
            tick();
            cycles++;
        end
        check_eq({tag, "_seen"}, int'(want_done ? bus.done : bus.ir_next), 1);
    endtask

    task automatic stream(input int beats, input int abort_at);
        for (int b = 0; b < beats; b++) begin
            bus.ir_val  = 1'b1;
            bus.ir_rdy  = 1'b1;
            bus.ir_last = (b == beats - 1);
            bus.abort   = (b == abort_at);
            tick();
        end
        bus.ir_val  = 1'b0;
        bus.ir_rdy  = 1'b0;
        bus.ir_last = 1'b0;
        bus.abort   = 1'b0;
    endtask

    task automatic snap();
        b_irn = irn;
        b_kn  = kn;
        b_dn  = dn;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.cfg_data = '0; bus.cfg_addr = '0; bus.cfg_valid = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.ker_ready = 1'b0;
        bus.ir_val = 1'b0; bus.ir_rdy = 1'b0; bus.ir_last = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy",     int'(bus.busy), 0);
        check_eq("rst_done",     int'(bus.done), 0);
        check_eq("rst_err",      int'(bus.err), 0);
        check_eq("rst_pass_cnt", int'(bus.pass_cnt), 0);
        check_eq("rst_ir_next",  int'(bus.ir_next), 0);
        check_eq("rst_ker_next", int'(bus.ker_next), 0);
        rst = 1'b0;
        tick();

        // Three passes; other-address write ignored, mid-run write deferred.
        cfg_write(19, 7);
        cfg_write(20, 2);
        snap();
        bus.ker_ready = 1'b1;
        pulse_start();
        check_eq("t1_busy", int'(bus.busy), 1);
        wait_for("t1_p1", 1'b0, 20, cyc);
        check_eq("t1_first_ir", cyc, 2);
        cfg_write(20, 0);
        stream(10, -1);
        wait_for("t1_p2", 1'b0, 40, cyc);
        stream(10, -1);
        wait_for("t1_p3", 1'b0, 40, cyc);
        check_eq("t1_spacing", cyc + 10, 16);
        stream(10, -1);
        wait_for("t1_done", 1'b1, 20, cyc);
        check_eq("t1_done_lat", cyc, 4);
        tick();
        check_eq("t1_pass_cnt", int'(bus.pass_cnt), 3);
        check_eq("t1_ir_next_n", irn - b_irn, 3);
        check_eq("t1_ker_next_n", kn - b_kn, 3);
        check_eq("t1_done_n", dn - b_dn, 1);
        check_eq("t1_busy_end", int'(bus.busy), 0);
        check_eq("t1_err", int'(bus.err), 0);

        // Kernel stall, then a last beat held off by back-pressure.
        snap();
        bus.ker_ready = 1'b0;
        pulse_start();
        repeat (50) tick();
        check_eq("t2_no_ir_next", irn - b_irn, 0);
        check_eq("t2_busy", int'(bus.busy), 1);
        bus.ker_ready = 1'b1;
        wait_for("t2_ir", 1'b0, 10, cyc);
        check_eq("t2_ir_lat", cyc, 2);
        bus.ir_val = 1'b1;
        bus.ir_rdy = 1'b1;
        repeat (3) tick();
        bus.ir_last = 1'b1;
        bus.ir_rdy  = 1'b0;
        repeat (5) tick();
        check_eq("t2_stall_pass_cnt", int'(bus.pass_cnt), 0);
        check_eq("t2_stall_ker_next", kn - b_kn, 0);
        bus.ir_rdy = 1'b1;
        tick();
        bus.ir_val = 1'b0; bus.ir_rdy = 1'b0; bus.ir_last = 1'b0;
        check_eq("t2_accept_pass_cnt", int'(bus.pass_cnt), 1);
        check_eq("t2_accept_ker_next", int'(bus.ker_next), 1);
        wait_for("t2_done", 1'b1, 20, cyc);
        tick();
        check_eq("t2_pass_cnt", int'(bus.pass_cnt), 1);
        check_eq("t2_done_n", dn - b_dn, 1);

        // Stream never ends: watchdog expires after 63 RUN cycles.
        snap();
        pulse_start();
        wait_for("t4_ir", 1'b0, 10, cyc);
        wait_for("t4_done", 1'b1, 100, cyc);
        check_eq("t4_tmo_lat", cyc, 63);
        check_eq("t4_err", int'(bus.err), 1);
        check_eq("t4_busy", int'(bus.busy), 0);
        tick();
        check_eq("t4_ker_next_n", kn - b_kn, 1);
        check_eq("t4_pass_cnt", int'(bus.pass_cnt), 0);
        repeat (3) tick();
        check_eq("t4_err_sticky", int'(bus.err), 1);

        // Abort during pass 2 of 5: pass 2 drains, nothing further issued.
        cfg_write(20, 4);
        snap();
        pulse_start();
        check_eq("t5_err_cleared", int'(bus.err), 0);
        wait_for("t5_p1", 1'b0, 10, cyc);
        stream(10, -1);
        wait_for("t5_p2", 1'b0, 40, cyc);
        stream(10, 3);
        wait_for("t5_done", 1'b1, 40, cyc);
        tick();
        check_eq("t5_pass_cnt", int'(bus.pass_cnt), 2);
        check_eq("t5_ir_next_n", irn - b_irn, 2);
        check_eq("t5_ker_next_n", kn - b_kn, 2);
        check_eq("t5_done_n", dn - b_dn, 1);

        // start and abort together in IDLE: abort dropped.
        cfg_write(20, 1);
        snap();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int p = 0; p < 2; p++) begin
            wait_for("t6_p", 1'b0, 40, cyc);
            stream(10, -1);
        end
        wait_for("t6_done", 1'b1, 20, cyc);
        tick();
        check_eq("t6_pass_cnt", int'(bus.pass_cnt), 2);
        check_eq("t6_ir_next_n", irn - b_irn, 2);

        // Abort while waiting for a kernel bank.
        snap();
        bus.ker_ready = 1'b0;
        pulse_start();
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_for("t7_done", 1'b1, 5, cyc);
        check_eq("t7_done_lat", cyc, 0);
        tick();
        check_eq("t7_pass_cnt", int'(bus.pass_cnt), 0);
        check_eq("t7_ir_next_n", irn - b_irn, 0);
        check_eq("t7_ker_next_n", kn - b_kn, 0);

        // Reset in RUN of pass 2, then a fresh run (cfg back to 1 pass).
        bus.ker_ready = 1'b1;
        pulse_start();
        wait_for("t8_p1", 1'b0, 10, cyc);
        stream(10, -1);
        wait_for("t8_p2", 1'b0, 40, cyc);
        bus.ir_val = 1'b1;
        bus.ir_rdy = 1'b1;
        repeat (2) tick();
        check_eq("t8_pre_pass_cnt", int'(bus.pass_cnt), 1);
        snap();
        rst = 1'b1;
        bus.ir_val = 1'b0;
        bus.ir_rdy = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("t8_busy", int'(bus.busy), 0);
        check_eq("t8_pass_cnt", int'(bus.pass_cnt), 0);
        repeat (10) tick();
        check_eq("t8_no_ker_next", kn - b_kn, 0);
        check_eq("t8_no_done", dn - b_dn, 0);
        snap();
        pulse_start();
        wait_for("t8_new_p1", 1'b0, 10, cyc);
        stream(10, -1);
        wait_for("t8_new_done", 1'b1, 20, cyc);
        tick();
        check_eq("t8_new_pass_cnt", int'(bus.pass_cnt), 1);
        check_eq("t8_new_ir_next_n", irn - b_irn, 1);
        check_eq("t8_new_ker_next_n", kn - b_kn, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
